// File: rtl/floo_tile_local_mux.sv
// floo_tile_local_mux: shares one router local port among NumLocal network interfaces.
// Injection: round-robin, packet-locked arbiter feeding a single-entry output register.
// Ejection: combinational demux on a local-index field carried in the flit; flits that
// address a non-existent local are absorbed, flagged on err_o and counted.
module floo_tile_local_mux #(
  parameter int unsigned NumLocal  = 2,
  parameter int unsigned FlitWidth = 64,
  parameter int unsigned DstLsb    = 0,
  parameter int unsigned IdxW      = (NumLocal > 1) ? $clog2(NumLocal) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  // injection from locals
  input  logic [NumLocal-1:0]                 in_valid_i,
  output logic [NumLocal-1:0]                 in_ready_o,
  input  logic [NumLocal-1:0][FlitWidth-1:0]  in_data_i,
  input  logic [NumLocal-1:0]                 in_last_i,
  // merged stream to router
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [FlitWidth-1:0]                out_data_o,
  output logic                                out_last_o,
  // ejection from router
  input  logic                                rtr_valid_i,
  output logic                                rtr_ready_o,
  input  logic [FlitWidth-1:0]                rtr_data_i,
  input  logic                                rtr_last_i,
  // ejection to locals
  output logic [NumLocal-1:0]                 loc_valid_o,
  input  logic [NumLocal-1:0]                 loc_ready_i,
  output logic [FlitWidth-1:0]                loc_data_o,
  output logic                                loc_last_o,
  // drop reporting
  output logic                                err_o,
  output logic [7:0]                          drop_cnt_o
);

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e                r_state, w_state_nxt;
  logic [IdxW-1:0]       r_rr, w_rr_nxt;
  logic [IdxW-1:0]       r_lock, w_lock_nxt;
  logic [IdxW-1:0]       w_gnt_idx;
  logic                  w_gnt_vld;
  int unsigned           w_best, w_dist;
  logic [FlitWidth-1:0]  w_sel_data;
  logic                  w_sel_last;
  logic                  w_can_accept;
  logic                  w_hs;

  logic                  r_out_valid;
  logic [FlitWidth-1:0]  r_out_data;
  logic                  r_out_last;

  logic [IdxW-1:0]       w_idx;
  logic                  w_idx_ok;
  logic                  w_drop;
  logic                  r_err;
  logic [7:0]            r_drop_cnt;

  // Output register can take a new flit when empty or draining this cycle.
  assign w_can_accept = !r_out_valid || out_ready_i;
  assign w_hs         = w_gnt_vld && w_can_accept;

  // Grant selection: held port while locked, else first valid at/after rr pointer.
  always_comb begin
    w_gnt_idx = '0;
    w_gnt_vld = 1'b0;
    w_best    = NumLocal;
    w_dist    = 0;
    if (r_state == S_LOCKED) begin
      w_gnt_idx = r_lock;
      for (int unsigned i = 0; i < NumLocal; i++) begin
        if (IdxW'(i) == r_lock) w_gnt_vld = in_valid_i[i];
      end
    end else begin
      for (int unsigned i = 0; i < NumLocal; i++) begin
        w_dist = (i >= 32'(r_rr)) ? (i - 32'(r_rr)) : (i + NumLocal - 32'(r_rr));
        if (in_valid_i[i] && (w_dist < w_best)) begin
          w_best    = w_dist;
          w_gnt_idx = IdxW'(i);
          w_gnt_vld = 1'b1;
        end
      end
    end
  end

  // Payload mux and per-port ready for the granted port.
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    in_ready_o = '0;
    for (int unsigned i = 0; i < NumLocal; i++) begin
      if (IdxW'(i) == w_gnt_idx) begin
        w_sel_data    = in_data_i[i];
        w_sel_last    = in_last_i[i];
        in_ready_o[i] = !rst_i && w_hs;
      end
    end
  end

  // Arbiter next state: lock on a non-last flit, release and advance rr on last.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_lock_nxt  = r_lock;
    if (w_hs) begin
      if (w_sel_last) begin
        w_state_nxt = S_IDLE;
        w_rr_nxt    = ((32'(w_gnt_idx) + 1) >= NumLocal) ? '0 : (w_gnt_idx + IdxW'(1));
      end else begin
        w_state_nxt = S_LOCKED;
        w_lock_nxt  = w_gnt_idx;
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_lock  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_lock  <= w_lock_nxt;
    end
  end

  // Single-entry output register; holds until the router takes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_hs) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_last_o  = r_out_last;

  assign w_idx    = rtr_data_i[DstLsb +: IdxW];
  assign w_idx_ok = (32'(w_idx) < NumLocal);
  assign w_drop   = rtr_valid_i && !w_idx_ok;

  // Ejection demux; out-of-range index is always accepted and discarded.
  always_comb begin
    loc_valid_o = '0;
    rtr_ready_o = 1'b1;
    if (w_idx_ok) begin
      for (int unsigned i = 0; i < NumLocal; i++) begin
        if (IdxW'(i) == w_idx) begin
          loc_valid_o[i] = rtr_valid_i;
          rtr_ready_o    = loc_ready_i[i];
        end
      end
    end
  end

  assign loc_data_o = rtr_data_i;
  assign loc_last_o = rtr_last_i;

  // Drop pulse and saturating drop counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_err <= w_drop;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign err_o      = r_err;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_floo_tile_local_mux.sv
// Bench for floo_tile_local_mux: NumLocal=4 (injection + ejection), NumLocal=3 with
// DstLsb=4 (ejection / drop counter), NumLocal=1 (pass-through and idx-1 drop).
module tb_floo_tile_local_mux;
  localparam int FW = 16;

  logic clk;
  logic rst;

  // NumLocal = 4
  logic [3:0]         in_valid4, in_ready4, in_last4;
  logic [3:0][FW-1:0] in_data4;
  logic               out_valid4, out_ready4, out_last4;
  logic [FW-1:0]      out_data4;
  logic               rtr_valid4, rtr_ready4, rtr_last4;
  logic [FW-1:0]      rtr_data4;
  logic [3:0]         loc_valid4, loc_ready4;
  logic [FW-1:0]      loc_data4;
  logic               loc_last4, err4;
  logic [7:0]         drop4;

  // NumLocal = 3
  logic [2:0]         in_valid3, in_ready3, in_last3;
  logic [2:0][FW-1:0] in_data3;
  logic               out_valid3, out_ready3, out_last3;
  logic [FW-1:0]      out_data3;
  logic               rtr_valid3, rtr_ready3, rtr_last3;
  logic [FW-1:0]      rtr_data3;
  logic [2:0]         loc_valid3, loc_ready3;
  logic [FW-1:0]      loc_data3;
  logic               loc_last3, err3;
  logic [7:0]         drop3;

  // NumLocal = 1
  logic [0:0]         in_valid1, in_ready1, in_last1;
  logic [0:0][FW-1:0] in_data1;
  logic               out_valid1, out_ready1, out_last1;
  logic [FW-1:0]      out_data1;
  logic               rtr_valid1, rtr_ready1, rtr_last1;
  logic [FW-1:0]      rtr_data1;
  logic [0:0]         loc_valid1, loc_ready1;
  logic [FW-1:0]      loc_data1;
  logic               loc_last1, err1;
  logic [7:0]         drop1;

  floo_tile_local_mux #(.NumLocal(4), .FlitWidth(FW), .DstLsb(0)) u4 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid4), .in_ready_o(in_ready4), .in_data_i(in_data4), .in_last_i(in_last4),
    .out_valid_o(out_valid4), .out_ready_i(out_ready4), .out_data_o(out_data4), .out_last_o(out_last4),
    .rtr_valid_i(rtr_valid4), .rtr_ready_o(rtr_ready4), .rtr_data_i(rtr_data4), .rtr_last_i(rtr_last4),
    .loc_valid_o(loc_valid4), .loc_ready_i(loc_ready4), .loc_data_o(loc_data4), .loc_last_o(loc_last4),
    .err_o(err4), .drop_cnt_o(drop4));

  floo_tile_local_mux #(.NumLocal(3), .FlitWidth(FW), .DstLsb(4)) u3 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid3), .in_ready_o(in_ready3), .in_data_i(in_data3), .in_last_i(in_last3),
    .out_valid_o(out_valid3), .out_ready_i(out_ready3), .out_data_o(out_data3), .out_last_o(out_last3),
    .rtr_valid_i(rtr_valid3), .rtr_ready_o(rtr_ready3), .rtr_data_i(rtr_data3), .rtr_last_i(rtr_last3),
    .loc_valid_o(loc_valid3), .loc_ready_i(loc_ready3), .loc_data_o(loc_data3), .loc_last_o(loc_last3),
    .err_o(err3), .drop_cnt_o(drop3));

  floo_tile_local_mux #(.NumLocal(1), .FlitWidth(FW), .DstLsb(0)) u1 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid1), .in_ready_o(in_ready1), .in_data_i(in_data1), .in_last_i(in_last1),
    .out_valid_o(out_valid1), .out_ready_i(out_ready1), .out_data_o(out_data1), .out_last_o(out_last1),
    .rtr_valid_i(rtr_valid1), .rtr_ready_o(rtr_ready1), .rtr_data_i(rtr_data1), .rtr_last_i(rtr_last1),
    .loc_valid_o(loc_valid1), .loc_ready_i(loc_ready1), .loc_data_o(loc_data1), .loc_last_o(loc_last1),
    .err_o(err1), .drop_cnt_o(drop1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (NumLocal=4 injection, NumLocal=3 drop reporting).
  bit            m_locked;
  int            m_owner;
  int            m_rr;
  bit            m_ovld;
  logic [FW-1:0] m_odata;
  bit            m_olast;
  bit            m_err3;
  int            m_cnt3;

  int            hs_port;
  logic [3:0]    smp_ready;
  logic [FW-1:0] q_out[$];
  int            s[4];

  typedef struct {
    logic [1:0] idx;
    logic       vld;
    logic [2:0] lrdy;
    logic [2:0] exp_lv;
    logic       exp_rr;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int p);
    return FW'((p << 12) | (s[p] & 'hFFF));
  endfunction

  // One clock: compare DUT against the model at mid-low phase, advance model, step clock.
  task automatic cyc();
    int         g, idx, idx3;
    bit         any, can;
    logic [3:0] er, elv;
    logic [2:0] elv3;
    logic       er3;
    #1;
    can = !m_ovld || out_ready4;
    any = 1'b0;
    g   = 0;
    if (m_locked) begin
      g   = m_owner;
      any = in_valid4[g];
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (!any && in_valid4[(m_rr + d) % 4]) begin
          any = 1'b1;
          g   = (m_rr + d) % 4;
        end
      end
    end
    er = '0;
    if (any && can) er[g] = 1'b1;
    smp_ready = in_ready4;
    chk("in_ready", 32'(in_ready4), 32'(er));
    chk("out_valid", 32'(out_valid4), 32'(m_ovld));
    if (m_ovld) begin
      chk("out_data", 32'(out_data4), 32'(m_odata));
      chk("out_last", 32'(out_last4), 32'(m_olast));
    end
    idx = int'(rtr_data4[1:0]);
    elv = '0;
    if (rtr_valid4) elv[idx] = 1'b1;
    chk("loc_valid4", 32'(loc_valid4), 32'(elv));
    chk("rtr_ready4", 32'(rtr_ready4), 32'(loc_ready4[idx]));
    chk("err4", 32'(err4), 32'(0));
    idx3 = int'(rtr_data3[5:4]);
    elv3 = '0;
    er3  = 1'b1;
    if (idx3 < 3) begin
      if (rtr_valid3) elv3[idx3] = 1'b1;
      er3 = loc_ready3[idx3];
    end
    chk("loc_valid3", 32'(loc_valid3), 32'(elv3));
    chk("rtr_ready3", 32'(rtr_ready3), 32'(er3));
    chk("loc_data3", 32'(loc_data3), 32'(rtr_data3));
    chk("err3", 32'(err3), 32'(m_err3));
    chk("drop_cnt3", 32'(drop3), 32'(m_cnt3));
    if (out_valid4 && out_ready4) q_out.push_back(out_data4);
    hs_port = -1;
    if (m_ovld && out_ready4) m_ovld = 1'b0;
    if (any && can) begin
      hs_port = g;
      m_ovld  = 1'b1;
      m_odata = in_data4[g];
      m_olast = in_last4[g];
      if (in_last4[g]) begin
        m_locked = 1'b0;
        m_rr     = (g + 1) % 4;
      end else begin
        m_locked = 1'b1;
        m_owner  = g;
      end
    end
    m_err3 = rtr_valid3 && (idx3 >= 3);
    if (m_err3 && m_cnt3 < 255) m_cnt3++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid4), 32'(0));
    chk("rst_out_data", 32'(out_data4), 32'(0));
    chk("rst_out_last", 32'(out_last4), 32'(0));
    chk("rst_in_ready", 32'(in_ready4), 32'(0));
    chk("rst_err3", 32'(err3), 32'(0));
    chk("rst_drop3", 32'(drop3), 32'(0));
    m_locked = 1'b0; m_owner = 0; m_rr = 0; m_ovld = 1'b0;
    m_err3 = 1'b0;   m_cnt3 = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_idle();
    in_valid4 = '0; in_last4 = '0; out_ready4 = 1'b1;
    rtr_valid4 = 1'b0; rtr_data4 = '0; loc_ready4 = '0;
    rtr_valid3 = 1'b0; rtr_data3 = '0; loc_ready3 = '0;
  endtask

  initial begin
    logic [FW-1:0] w;
    int n0;
    bit done2;

    rst = 1'b1;
    in_valid4 = '0; in_last4 = '0; in_data4 = '0; out_ready4 = 1'b1;
    rtr_valid4 = 1'b0; rtr_data4 = '0; rtr_last4 = 1'b0; loc_ready4 = '0;
    in_valid3 = '0; in_last3 = '0; in_data3 = '0; out_ready3 = 1'b1;
    rtr_valid3 = 1'b0; rtr_data3 = '0; rtr_last3 = 1'b0; loc_ready3 = '0;
    in_valid1 = '0; in_last1 = '0; in_data1 = '0; out_ready1 = 1'b1;
    rtr_valid1 = 1'b0; rtr_data1 = '0; rtr_last1 = 1'b0; loc_ready1 = '0;
    for (int p = 0; p < 4; p++) s[p] = 0;

    //           idx   vld   lrdy    exp_lv  exp_rr
    tv[0] = '{2'd0, 1'b1, 3'b001, 3'b001, 1'b1};
    tv[1] = '{2'd1, 1'b1, 3'b001, 3'b010, 1'b0};
    tv[2] = '{2'd2, 1'b1, 3'b100, 3'b100, 1'b1};
    tv[3] = '{2'd2, 1'b0, 3'b100, 3'b000, 1'b1};
    tv[4] = '{2'd3, 1'b1, 3'b000, 3'b000, 1'b1};
    tv[5] = '{2'd1, 1'b1, 3'b010, 3'b010, 1'b1};
    tv[6] = '{2'd0, 1'b0, 3'b110, 3'b000, 1'b0};

    @(negedge clk);
    do_reset();

    // Ejection table on the NumLocal=3 instance (index field at bit 4).
    for (int t = 0; t < 7; t++) begin
      rtr_valid3 = tv[t].vld;
      rtr_data3  = (16'($urandom) & 16'hFFCF) | (16'(tv[t].idx) << 4);
      loc_ready3 = tv[t].lrdy;
      #1;
      chk("tbl_loc_valid", 32'(loc_valid3), 32'(tv[t].exp_lv));
      chk("tbl_rtr_ready", 32'(rtr_ready3), 32'(tv[t].exp_rr));
      cyc();
    end
    set_idle(); cyc();

    // Ports 1 and 3 stream single-flit packets: grants alternate 1,3,1,3.
    do_reset(); q_out.delete();
    in_last4 = 4'hF; in_valid4 = 4'b1010;
    in_data4[1] = mk(1); in_data4[3] = mk(3);
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (c == 0) chk("first_grant", 32'(hs_port), 32'(1));
      if (hs_port >= 0) begin s[hs_port]++; in_data4[hs_port] = mk(hs_port); end
    end
    chk("alt_count", 32'(q_out.size()), 32'(7));
    for (int k = 0; k < q_out.size(); k++) begin
      w = q_out[k];
      chk("alt_order", 32'(w[15:12]), (k % 2 == 0) ? 32'(1) : 32'(3));
    end
    set_idle(); cyc(); cyc();

    // 3-flit packet on port 0 holds off port 2 until its last flit.
    do_reset(); q_out.delete();
    n0 = 0; done2 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      in_valid4[0] = (n0 < 3);
      in_last4[0]  = (n0 == 2);
      in_data4[0]  = mk(0);
      in_valid4[2] = (c >= 1) && !done2;
      in_last4[2]  = 1'b1;
      in_data4[2]  = mk(2);
      cyc();
      if (c == 1 || c == 2) chk("lock_block2", 32'(smp_ready[2]), 32'(0));
      if (hs_port == 0) begin n0++; s[0]++; end
      if (hs_port == 2) begin done2 = 1'b1; s[2]++; end
    end
    chk("lock_count", 32'(q_out.size()), 32'(4));
    for (int k = 0; k < q_out.size(); k++) begin
      w = q_out[k];
      chk("lock_order", 32'(w[15:12]), (k < 3) ? 32'(0) : 32'(2));
    end
    set_idle(); cyc(); cyc();

    // Back-pressure: out_ready low 5 cycles, data held, then resume without loss.
    do_reset(); q_out.delete();
    s[1] = 0;
    in_valid4 = 4'b0010; in_last4 = 4'b0010; in_data4[1] = mk(1); out_ready4 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      if (c >= 1) chk("stall_ready1", 32'(smp_ready[1]), 32'(0));
      if (hs_port == 1) begin s[1]++; in_data4[1] = mk(1); end
    end
    out_ready4 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (hs_port == 1) begin s[1]++; in_data4[1] = mk(1); end
    end
    in_valid4 = '0; cyc(); cyc();
    chk("stall_count", 32'(q_out.size()), 32'(s[1]));
    for (int k = 0; k < q_out.size(); k++) begin
      w = q_out[k];
      chk("stall_seq", 32'(w[11:0]), 32'(k));
    end
    set_idle(); cyc();

    // Out-of-range index drops; counter saturates at 255.
    do_reset();
    rtr_valid3 = 1'b1; rtr_data3 = 16'h0030; loc_ready3 = 3'b000;
    #1;
    chk("drop_rtr_ready", 32'(rtr_ready3), 32'(1));
    chk("drop_loc_valid", 32'(loc_valid3), 32'(0));
    cyc();
    rtr_valid3 = 1'b0;
    #1;
    chk("drop_err_pulse", 32'(err3), 32'(1));
    chk("drop_cnt_one", 32'(drop3), 32'(1));
    cyc();
    rtr_valid3 = 1'b1;
    for (int c = 0; c < 300; c++) begin
      rtr_data3 = 16'($urandom) | 16'h0030;
      cyc();
    end
    rtr_valid3 = 1'b0;
    cyc();
    chk("drop_saturate", 32'(drop3), 32'(255));
    set_idle(); cyc();

    // Reset in the middle of a 4-flit packet from port 2.
    do_reset();
    s[2] = 0;
    in_valid4 = 4'b0100; in_last4 = 4'b0000; in_data4[2] = mk(2);
    for (int c = 0; c < 2; c++) begin
      cyc();
      if (hs_port == 2) begin s[2]++; in_data4[2] = mk(2); end
    end
    do_reset();
    in_valid4 = 4'b0101; in_last4 = 4'b0101; in_data4[0] = mk(0);
    cyc();
    chk("post_rst_grant", 32'(hs_port), 32'(0));
    set_idle(); cyc(); cyc();

    // Concurrent injection from port 1 and ejection to local 2.
    do_reset();
    in_valid4 = 4'b0010; in_last4 = 4'b0010; in_data4[1] = mk(1);
    rtr_valid4 = 1'b1; rtr_data4 = 16'h1232; loc_ready4 = 4'b0100;
    #1;
    chk("concur_in_ready1", 32'(in_ready4[1]), 32'(1));
    chk("concur_rtr_ready", 32'(rtr_ready4), 32'(1));
    chk("concur_loc_valid", 32'(loc_valid4), 32'(4'b0100));
    cyc();
    set_idle(); cyc();

    // Single-local instance: pass-through and index 1 is out of range.
    do_reset();
    in_valid1 = 1'b1; in_last1 = 1'b1; in_data1[0] = 16'hABCD; out_ready1 = 1'b1;
    rtr_valid1 = 1'b1; rtr_data1 = 16'h0001; loc_ready1 = 1'b0;
    #1;
    chk("n1_in_ready", 32'(in_ready1), 32'(1));
    chk("n1_rtr_ready", 32'(rtr_ready1), 32'(1));
    chk("n1_loc_valid", 32'(loc_valid1), 32'(0));
    cyc();
    in_valid1 = 1'b0; rtr_data1 = 16'h0000; loc_ready1 = 1'b1;
    #1;
    chk("n1_out_valid", 32'(out_valid1), 32'(1));
    chk("n1_out_data", 32'(out_data1), 32'(16'hABCD));
    chk("n1_out_last", 32'(out_last1), 32'(1));
    chk("n1_err", 32'(err1), 32'(1));
    chk("n1_drop", 32'(drop1), 32'(1));
    chk("n1_loc_valid0", 32'(loc_valid1), 32'(1));
    chk("n1_rtr_ready0", 32'(rtr_ready1), 32'(1));
    cyc();
    rtr_valid1 = 1'b0;
    #1;
    chk("n1_err_clear", 32'(err1), 32'(0));
    chk("n1_out_drained", 32'(out_valid1), 32'(0));
    cyc();

    // Randomized traffic on both paths against the model.
    set_idle(); do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < 4; p++) begin
        if (!in_valid4[p] && $urandom_range(0, 2) == 0) begin
          in_valid4[p] = 1'b1;
          in_last4[p]  = ($urandom_range(0, 2) == 0);
          in_data4[p]  = mk(p);
        end
      end
      out_ready4 = ($urandom_range(0, 3) != 0);
      rtr_valid4 = 1'($urandom); rtr_data4 = 16'($urandom); loc_ready4 = 4'($urandom);
      rtr_last4  = 1'($urandom);
      rtr_valid3 = 1'($urandom); rtr_data3 = 16'($urandom); loc_ready3 = 3'($urandom);
      cyc();
      if (hs_port >= 0) begin
        s[hs_port]++;
        in_valid4[hs_port] = 1'b0;
      end
    end
    set_idle(); cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/floo_tile_local_mux.md
FLOO_TILE_LOCAL_MUX -- requirements
Module: floo_tile_local_mux

Interface
REQ-001 SHALL have parameter NumLocal, default 2, number of local network interfaces sharing one router local port; legal range 1..8.
REQ-002 SHALL have parameter FlitWidth, default 64, flit payload width in bits.
REQ-003 SHALL have parameter DstLsb, default 0, LSB of the local-index field inside an inbound flit.
REQ-004 SHALL have parameter IdxW, default max(1,$clog2(NumLocal)), local-index field width.
REQ-005 SHALL use one clock, clk_i, with asynchronous, active-high reset rst_i.
REQ-006 clk_i  input  1  clock.
REQ-007 rst_i  input  1  asynchronous active-high reset.
REQ-008 in_valid_i  input  NumLocal  per-local injection valid.
REQ-009 in_ready_o  output  NumLocal  per-local injection ready.
REQ-010 in_data_i  input  NumLocal x FlitWidth  per-local injection flit.
REQ-011 in_last_i  input  NumLocal  last flit of packet.
REQ-012 out_valid_o / out_ready_i / out_data_o (FlitWidth) / out_last_o  output/input/output/output  merged stream to the router local port.
REQ-013 rtr_valid_i / rtr_ready_o / rtr_data_i (FlitWidth) / rtr_last_i  input/output/input/input  ejection stream from the router.
REQ-014 loc_valid_o (NumLocal) / loc_ready_i (NumLocal) / loc_data_o (FlitWidth) / loc_last_o  output/input/output/output  ejection stream to locals; data and last broadcast.
REQ-015 err_o  output  1  one-cycle pulse on dropped inbound flit.
REQ-016 drop_cnt_o  output  8  saturating count of dropped inbound flits.

Function
REQ-017 Injection arbiter SHALL have states IDLE and LOCKED plus a round-robin pointer rr_q (IdxW bits).
REQ-018 In IDLE, grant SHALL go to the first valid port at or after rr_q (wrapping modulo NumLocal).
REQ-019 Output register SHALL accept a flit when it is empty or out_valid_o & out_ready_i in the same cycle; no bubble at full throughput.
REQ-020 in_ready_o[i] SHALL be 1 only for the granted port and only when the output register can accept; all others 0.
REQ-021 Accepting a flit with in_last_i=0 SHALL move IDLE->LOCKED holding that port; no other port granted until the port's last flit is accepted.
REQ-022 Accepting a flit with in_last_i=1 (from IDLE or LOCKED) SHALL go to IDLE and set rr_q to granted index+1 modulo NumLocal.
REQ-023 In LOCKED with the held port not valid, SHALL stay LOCKED and grant nothing.
REQ-024 Injection latency SHALL be exactly 1 cycle from in handshake to out_valid_o; data and last unmodified.
REQ-025 out_valid_o SHALL stay high with stable data/last until out_ready_i.
REQ-026 Ejection SHALL be combinational: idx = rtr_data_i[DstLsb +: IdxW]; loc_valid_o[idx]=rtr_valid_i, other bits 0; rtr_ready_o=loc_ready_i[idx].
REQ-027 If idx >= NumLocal, SHALL drive no loc_valid_o, rtr_ready_o=1, drop the flit, pulse err_o next cycle, increment drop_cnt_o saturating at 255.
REQ-028 With NumLocal=1, arbiter SHALL pass port 0 through the output register; idx check still applied (idx 1 drops).
REQ-029 Injection and ejection paths SHALL be independent; simultaneous traffic on both SHALL not stall either.

Reset
REQ-030 While rst_i high: state IDLE, rr_q=0, out_valid_o=0, out_data_o=0, out_last_o=0, in_ready_o=0, err_o=0, drop_cnt_o=0.
REQ-031 Reset asserted mid-packet SHALL discard the held flit and lock; first cycle after deassertion arbitrates from port 0.

Verification
REQ-032 NumLocal=4, ports 1 and 3 send single-flit packets continuously, out_ready_i=1 -> output alternates 1,3,1,3 one flit/cycle, first out_valid_o 1 cycle after first handshake.
REQ-033 Port 0 sends 3-flit packet, port 2 valid from cycle 1 -> out carries 0,0,0 then 2; in_ready_o[2]=0 until port 0 last accepted.
REQ-034 out_ready_i held 0 for 5 cycles with port 1 valid -> out_valid_o=1, out_data_o stable, in_ready_o[1]=0 after first accept; resumes without loss.
REQ-035 NumLocal=3, inbound flit with idx=3 -> rtr_ready_o=1, loc_valid_o=000, err_o pulse next cycle, drop_cnt_o 0->1; 300 such flits -> drop_cnt_o=255.
REQ-036 Assert rst_i mid 4-flit packet from port 2 -> out_valid_o=0 immediately; after release, port 0 and port 2 both valid -> port 0 granted first.
REQ-037 Simultaneous injection from port 1 and ejection to idx 2 with loc_ready_i[2]=1 -> both complete in the same cycle, no stall.
